// File: rtl/scu_dsp_dma_ctl.sv
// rtl/scu_dsp_dma_ctl.sv - SCU DSP bus-side DMA engine: one bus word per DSP request.
// Optional bus watchdog enabled by defining SCUDSP_DMA_TIMEOUT_EN.
module scu_dsp_dma_ctl #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int END_CEF     = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic [31:0] DSO,
  input  logic        RA0W,
  input  logic        WA0W,
  input  logic        DMAW,
  input  logic [31:0] DMA_DO,
  input  logic        DMA_WE,
  input  logic        DMA_REQ,
  input  logic        DMA_RUN,
  input  logic        DMA_LAST,
  output logic [31:0] DMA_DI,
  output logic        DMA_ACK,
  output logic        DMA_END,
  output logic [26:0] BUS_ADDR,
  output logic [31:0] BUS_DO,
  output logic        BUS_WE,
  output logic        BUS_REQ,
  input  logic [31:0] BUS_DI,
  input  logic        BUS_ACK,
  output logic        BUS_ERR
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSW = 2'd1;
  localparam logic [1:0] S_HSK  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int ECW = $clog2(END_CEF + 1);
  localparam logic [ECW-1:0] END_LAST = ECW'(END_CEF - 1);

  logic [1:0]     state;
  logic [24:0]    ra0, wa0, ptr;
  logic [2:0]     add;
  logic           hold, dir, wb_pend;
  logic [ECW-1:0] end_cnt;
  logic           tmo_hit;

  logic [31:0] dma_di, bus_do;
  logic [26:0] bus_addr;
  logic        dma_ack, dma_end, bus_we, bus_req;

  // Word-address increment: writes step by the ADD code, reads always by one word.
  function automatic logic [24:0] ptr_step(input logic wr, input logic [2:0] code);
    if (!wr) return 25'd1;
    if (code == 3'd0) return 25'd0;
    return 25'd1 << (code - 3'd1);
  endfunction

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      ra0      <= '0;
      wa0      <= '0;
      ptr      <= '0;
      add      <= '0;
      hold     <= 1'b0;
      dir      <= 1'b0;
      wb_pend  <= 1'b0;
      end_cnt  <= '0;
      dma_di   <= '0;
      dma_ack  <= 1'b0;
      dma_end  <= 1'b0;
      bus_addr <= '0;
      bus_do   <= '0;
      bus_we   <= 1'b0;
      bus_req  <= 1'b0;
    end else begin
      if (RA0W) ra0 <= DSO[24:0];
      if (WA0W) wa0 <= DSO[24:0];

      case (state)
        S_IDLE: begin
          if (DMAW) begin
            hold <= DSO[14];
            add  <= DSO[17:15];
            dir  <= DSO[12];
            ptr  <= DSO[12] ? wa0 : ra0;
          end else if (DMA_RUN && DMA_REQ) begin
            bus_do   <= DMA_DO;
            bus_addr <= {ptr, 2'b00};
            bus_we   <= DMA_WE;
            bus_req  <= 1'b1;
            state    <= S_BUSW;
          end
        end
        S_BUSW: begin
          if (!DMA_RUN) begin
            bus_req <= 1'b0;
            state   <= S_IDLE;
          end else if (BUS_ACK || tmo_hit) begin
            bus_req <= 1'b0;
            if (tmo_hit)
              dma_di <= '0;
            else if (!bus_we)
              dma_di <= BUS_DI;
            ptr     <= ptr + ptr_step(dir, add);
            dma_ack <= 1'b1;
            state   <= S_HSK;
          end
        end
        S_HSK: begin
          if (!DMA_RUN) begin
            dma_ack <= 1'b0;
            state   <= S_IDLE;
          end else if (CE_R) begin
            // The DSP consumes the word and samples DMA_LAST on this same edge.
            dma_ack <= 1'b0;
            if (DMA_LAST) begin
              dma_end <= 1'b1;
              end_cnt <= '0;
              wb_pend <= ~hold;
              state   <= S_DONE;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_DONE: begin
          // Placed after the RA0W/WA0W loads so the writeback wins a same-cycle write.
          if (wb_pend) begin
            wb_pend <= 1'b0;
            if (dir) wa0 <= ptr;
            else     ra0 <= ptr;
          end
          if (CE_F) begin
            if (end_cnt == END_LAST) begin
              dma_end <= 1'b0;
              state   <= S_IDLE;
            end else begin
              end_cnt <= end_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SCUDSP_DMA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo_cnt;
  logic          bus_err;

  assign tmo_hit = (state == S_BUSW) && !BUS_ACK && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tmo_cnt <= '0;
      bus_err <= 1'b0;
    end else begin
      if (state == S_BUSW) tmo_cnt <= tmo_cnt + 1'b1;
      else                 tmo_cnt <= '0;
      if (tmo_hit && DMA_RUN) bus_err <= 1'b1;
    end
  end

  assign BUS_ERR = bus_err;
`else
  assign tmo_hit = (TIMEOUT_CYC < 0);
  assign BUS_ERR = 1'b0;
`endif

  logic unused_dso;
  assign unused_dso = ^DSO[31:25];

  assign DMA_DI   = dma_di;
  assign DMA_ACK  = dma_ack;
  assign DMA_END  = dma_end;
  assign BUS_ADDR = bus_addr;
  assign BUS_DO   = bus_do;
  assign BUS_WE   = bus_we;
  assign BUS_REQ  = bus_req;

endmodule

// File: tb/tb_scu_dsp_dma_ctl.sv
// tb/tb_scu_dsp_dma_ctl.sv - self-checking bench for scu_dsp_dma_ctl.
module tb_scu_dsp_dma_ctl;
  localparam int END_CEF = 2;
  localparam int TMO     = 8;

  logic        CLK = 1'b0;
  logic        RST_N, CE_R, CE_F, RA0W, WA0W, DMAW, DMA_WE, DMA_REQ, DMA_RUN, DMA_LAST, BUS_ACK;
  logic [31:0] DSO, DMA_DO, BUS_DI;
  logic [31:0] DMA_DI, BUS_DO;
  logic        DMA_ACK, DMA_END, BUS_WE, BUS_REQ, BUS_ERR;
  logic [26:0] BUS_ADDR;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cyc = 0;
  int bus_lat = 3;
  bit bus_en = 1'b1;
  logic [31:0] bus_rdata = '0;
  int unsigned ra0_m = 0, wa0_m = 0;
  int add_words[8] = '{0, 1, 2, 4, 8, 16, 32, 64};

  scu_dsp_dma_ctl #(.TIMEOUT_CYC(TMO), .END_CEF(END_CEF)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .DSO(DSO),
    .RA0W(RA0W), .WA0W(WA0W), .DMAW(DMAW), .DMA_DO(DMA_DO), .DMA_WE(DMA_WE),
    .DMA_REQ(DMA_REQ), .DMA_RUN(DMA_RUN), .DMA_LAST(DMA_LAST), .DMA_DI(DMA_DI),
    .DMA_ACK(DMA_ACK), .DMA_END(DMA_END), .BUS_ADDR(BUS_ADDR), .BUS_DO(BUS_DO),
    .BUS_WE(BUS_WE), .BUS_REQ(BUS_REQ), .BUS_DI(BUS_DI), .BUS_ACK(BUS_ACK), .BUS_ERR(BUS_ERR)
  );

  always #5 CLK = ~CLK;

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // CE_R every 4th clock, CE_F halfway between; value set at #2 applies to the next edge.
  initial begin
    CE_R = 1'b0;
    CE_F = 1'b0;
    forever begin
      @(posedge CLK);
      #2;
      CE_R = (cyc % 4 == 3);
      CE_F = (cyc % 4 == 1);
    end
  end

  // Bus slave: acknowledges each request bus_lat clocks after it appears.
  initial begin
    BUS_ACK = 1'b0;
    BUS_DI  = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (bus_en && BUS_REQ === 1'b1) begin
        repeat (bus_lat - 1) begin
          @(posedge CLK);
          #1;
        end
        BUS_DI  = bus_rdata;
        BUS_ACK = 1'b1;
        ack_cyc = cyc;
        @(posedge CLK);
        #1;
        BUS_ACK = 1'b0;
        BUS_DI  = $urandom;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_reg(input bit wa, input int unsigned val);
    DSO = val;
    if (wa) WA0W = 1'b1;
    else    RA0W = 1'b1;
    tick();
    RA0W = 1'b0;
    WA0W = 1'b0;
    if (wa) wa0_m = val % 33554432;
    else    ra0_m = val % 33554432;
  endtask

  task automatic dmaw(input bit dir, input logic [2:0] add, input bit hold);
    DSO  = (32'(add) << 15) | (32'(hold) << 14) | (32'(dir) << 12) | 32'h0000_0C21;
    DMAW = 1'b1;
    tick();
    DMAW = 1'b0;
    DSO  = $urandom;
  endtask

  task automatic dsp_word(input bit we, input logic [31:0] d, input bit last,
                          input int unsigned exp_addr, input string tag);
    int t;
    bit bad;
    DMA_WE   = we;
    DMA_DO   = d;
    DMA_LAST = last;
    DMA_REQ  = 1'b1;
    tick();
    chk({tag, "_req_lat"}, 64'(BUS_REQ), 64'd1);
    chk({tag, "_addr"}, 64'(BUS_ADDR), 64'(exp_addr));
    chk({tag, "_we"}, 64'(BUS_WE), 64'(we));
    if (we) chk({tag, "_bus_do"}, 64'(BUS_DO), 64'(d));
    t = 0;
    while (DMA_ACK !== 1'b1 && t < 200) begin
      tick();
      t++;
    end
    chk({tag, "_ack_seen"}, 64'(DMA_ACK), 64'd1);
    chk({tag, "_ack_lat"}, 64'(cyc - ack_cyc), 64'd1);
    if (!we) chk({tag, "_dma_di"}, 64'(DMA_DI), 64'(d));
    bad = 1'b0;
    t = 0;
    while (DMA_ACK === 1'b1 && t < 20) begin
      tick();
      t++;
      if (DMA_ACK === 1'b1 && CE_R === 1'b1) bad = 1'b1;
    end
    chk({tag, "_ack_held_past_ce_r"}, 64'(bad), 64'd0);
    chk({tag, "_ack_drop_on_ce_r"}, 64'(CE_R), 64'd1);
    DMA_REQ = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n, t;
    chk({tag, "_end_rise"}, 64'(DMA_END), 64'd1);
    n = 0;
    t = 0;
    while (DMA_END === 1'b1 && t < 100) begin
      tick();
      t++;
      if (CE_F === 1'b1) n++;
    end
    chk({tag, "_end_cef"}, 64'(n), 64'(END_CEF));
  endtask

  task automatic xfer(input bit dir, input logic [2:0] add, input bit hold, input int n,
                      input int lat, input logic [31:0] base, input logic [31:0] step,
                      input string tag);
    int unsigned p;
    logic [31:0] d;
    dmaw(dir, add, hold);
    p = dir ? wa0_m : ra0_m;
    DMA_RUN = 1'b1;
    for (int i = 0; i < n; i++) begin
      d = base + 32'(i) * step;
      bus_lat = (lat > 0) ? lat : $urandom_range(1, 5);
      bus_rdata = d;
      dsp_word(dir, d, i == n - 1, p * 4, $sformatf("%s_w%0d", tag, i));
      p = (p + (dir ? add_words[add] : 1)) % 33554432;
    end
    wait_end(tag);
    DMA_RUN = 1'b0;
    if (!hold) begin
      if (dir) wa0_m = p;
      else     ra0_m = p;
    end
  endtask

  initial begin
    int t;
    int t0;
    RST_N = 1'b0; RA0W = 1'b0; WA0W = 1'b0; DMAW = 1'b0; DSO = '0;
    DMA_DO = '0; DMA_WE = 1'b0; DMA_REQ = 1'b0; DMA_RUN = 1'b0; DMA_LAST = 1'b0;
    repeat (4) tick();
    chk("rst_dma_di", 64'(DMA_DI), 64'd0);
    chk("rst_dma_ack", 64'(DMA_ACK), 64'd0);
    chk("rst_dma_end", 64'(DMA_END), 64'd0);
    chk("rst_bus_addr", 64'(BUS_ADDR), 64'd0);
    chk("rst_bus_do", 64'(BUS_DO), 64'd0);
    chk("rst_bus_we_req", 64'({BUS_WE, BUS_REQ}), 64'd0);
    chk("rst_bus_err", 64'(BUS_ERR), 64'd0);
    RST_N = 1'b1;
    tick();

    // Read 3 words with writeback, then prove RA0 advanced via the next read address.
    set_reg(1'b0, 32'h0001000);
    xfer(1'b0, 3'd5, 1'b0, 3, 3, 32'hA, 32'h1, "rd3");
    chk("rd3_ra0_model", 64'(ra0_m), 64'h1003);
    xfer(1'b0, 3'd0, 1'b1, 1, 2, 32'h5A5A_0001, 32'h0, "rd_after_wb");

    // Write, ADD=011, HOLD=1; WA0 must stay 0x10.
    set_reg(1'b1, 32'h10);
    xfer(1'b1, 3'd3, 1'b1, 2, 2, 32'h1111_1111, 32'h1111_1111, "wr2");
    xfer(1'b1, 3'd3, 1'b1, 1, 1, 32'hCAFE_0000, 32'h0, "wr_hold_chk");

    // Pointer wrap at the top of the 25-bit word space.
    set_reg(1'b0, 32'h1FF_FFFF);
    xfer(1'b0, 3'd0, 1'b0, 2, 4, 32'h0BAD_F00D, 32'h3, "wrap");

    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 1) set_reg($urandom_range(0, 1) == 1, $urandom);
      xfer($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
           $urandom_range(1, 3), 0, $urandom, $urandom, $sformatf("rnd%0d", k));
    end

`ifdef SCUDSP_DMA_TIMEOUT_EN
    bus_en = 1'b0;
    dmaw(1'b0, 3'd0, 1'b0);
    DMA_RUN = 1'b1; DMA_WE = 1'b0; DMA_LAST = 1'b1; DMA_REQ = 1'b1;
    tick();
    chk("tmo_req", 64'(BUS_REQ), 64'd1);
    t0 = cyc;
    t = 0;
    while (DMA_ACK !== 1'b1 && t < 100) begin
      tick();
      t++;
    end
    chk("tmo_latency", 64'(cyc - t0), 64'(TMO));
    chk("tmo_dma_di", 64'(DMA_DI), 64'd0);
    chk("tmo_bus_err", 64'(BUS_ERR), 64'd1);
    t = 0;
    while (DMA_ACK === 1'b1 && t < 20) begin
      tick();
      t++;
    end
    DMA_REQ = 1'b0;
    wait_end("tmo");
    DMA_RUN = 1'b0;
    ra0_m = (ra0_m + 1) % 33554432;
    chk("tmo_bus_err_sticky", 64'(BUS_ERR), 64'd1);
    bus_en = 1'b1;
`else
    chk("no_tmo_bus_err", 64'(BUS_ERR), 64'd0);
`endif

    // Reset while waiting on the bus: everything clears, no DMA_END.
    bus_en = 1'b0;
    dmaw(1'b0, 3'd0, 1'b0);
    DMA_RUN = 1'b1; DMA_WE = 1'b1; DMA_DO = 32'h1234_5678; DMA_LAST = 1'b1; DMA_REQ = 1'b1;
    tick();
    chk("mid_rst_req_before", 64'(BUS_REQ), 64'd1);
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    DMA_REQ = 1'b0;
    DMA_RUN = 1'b0;
    chk("mid_rst_outputs", 64'({DMA_ACK, DMA_END, BUS_WE, BUS_REQ, BUS_ERR}), 64'd0);
    chk("mid_rst_addr_do", 64'({BUS_ADDR, BUS_DO}), 64'd0);
    chk("mid_rst_dma_di", 64'(DMA_DI), 64'd0);
    t = 0;
    repeat (10) begin
      tick();
      if (DMA_END !== 1'b0) t++;
    end
    chk("mid_rst_no_end", 64'(t), 64'd0);
    ra0_m = 0;
    wa0_m = 0;
    bus_en = 1'b1;
    xfer(1'b1, 3'd1, 1'b0, 2, 2, 32'h7777_0000, 32'h1, "post_rst");
    xfer(1'b1, 3'd0, 1'b1, 1, 1, 32'h0, 32'h0, "post_rst_wb");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scu_dsp_dma_ctl.md
Name: scu_dsp_dma_ctl

Overview:
- Bus-side DMA engine for the SCU DSP; sits directly downstream of the DSP core's DMA port.
- Latches the RA0/WA0 address writes and the DMA instruction word from the DSP.
- Performs one bus word transfer per DSP request, returns DMA_ACK/DMA_DI, and signals transfer completion with DMA_END.
- Transfer directions: DSP to bus (write) and bus to DSP (read).

Parameters:
- TIMEOUT_CYC, 1024: bus watchdog limit in clocks. Used only with the optional feature.
- END_CEF, 2: number of CE_F pulses for which DMA_END is held high.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  reset; synchronous, active-low
- CE_R  in  1  rising-phase clock enable, shared with the DSP core
- CE_F  in  1  falling-phase clock enable, shared with the DSP core
- DSO  in  32  DSP data out: D1BUS value, or the DMA instruction word when DMAW=1
- RA0W  in  1  DSP writes RA0
- WA0W  in  1  DSP writes WA0
- DMAW  in  1  DSP issues a DMA instruction
- DMA_DO  in  32  DSP data to bus
- DMA_WE  in  1  direction: 1 = DSP to bus (write), 0 = bus to DSP (read)
- DMA_REQ  in  1  DSP requests one word
- DMA_RUN  in  1  DSP DMA active (T0)
- DMA_LAST  in  1  current word is the last one
- DMA_DI  out  32  bus read data to DSP
- DMA_ACK  out  1  word accepted or delivered
- DMA_END  out  1  transfer finished; the DSP acts on its falling edge
- BUS_ADDR  out  27  byte address, {ptr,2'b00}
- BUS_DO  out  32  write data
- BUS_WE  out  1  write strobe qualifier
- BUS_REQ  out  1  bus request
- BUS_DI  in  32  read data
- BUS_ACK  in  1  one-cycle bus completion
- BUS_ERR  out  1  sticky timeout flag (optional feature only)

Behaviour:
- Reset values: all outputs 0. RA0, WA0, ptr, ADD, HOLD and state are cleared; state = IDLE. Reset is sampled every clock; asserting it mid-transfer aborts immediately with no DMA_END and no writeback.
- RA0W / WA0W, sampled on any clock: load RA0 / WA0 from DSO[24:0] (25-bit word address).
- DMAW: capture HOLD=DSO[14], ADD=DSO[17:15] and DIR=DSO[12], then load ptr from WA0 if DIR=1, else from RA0.
- Write increment per word, by ADD code: 000→0, 001→1, 010→2, 011→4, 100→8, 101→16, 110→32, 111→64 words.
- Read increment is always 1 word, regardless of ADD.
- ptr is 25 bits and wraps modulo 2^25.
- IDLE: when DMA_RUN && DMA_REQ, capture DMA_DO into BUS_DO, drive BUS_ADDR from ptr, set BUS_WE=DMA_WE and BUS_REQ=1, then go to BUSW.
- BUSW: hold BUS_REQ until BUS_ACK. On BUS_ACK:
  - drop BUS_REQ;
  - if read, latch BUS_DI into DMA_DI;
  - advance ptr by the increment;
  - go to HSK.
- HSK: drive DMA_ACK=1 until a clock with CE_R=1 (inclusive), then drop it. Sample DMA_LAST on that same clock: 1 → DONE, 0 → IDLE. The DSP updates DMA_REQ on that edge, so IDLE sees the fresh value.
- DONE:
  - if HOLD=0, write ptr back to RA0 (read) or WA0 (write); writeback beats a same-cycle RA0W/WA0W;
  - drive DMA_END=1 until END_CEF CE_F pulses have elapsed, then DMA_END=0 and go to IDLE.
- DMA_RUN dropping outside DONE: return to IDLE, drop BUS_REQ/DMA_ACK, no DMA_END.
- DMAW while not IDLE: ignored.
- RA0W/WA0W while busy: the register updates; ptr is unaffected.
- BUS_ACK outside BUSW: ignored.
- Latency: IDLE→BUS_REQ 1 clock; BUS_ACK→DMA_ACK 1 clock.

Optional Feature:
- Macro: SCUDSP_DMA_TIMEOUT_EN.
- Defined:
  - counter runs in BUSW; reaching TIMEOUT_CYC forces BUS_ACK-equivalent handling with DMA_DI=0;
  - sets BUS_ERR (sticky until reset); the transfer then proceeds normally.
- Undefined: BUSW waits indefinitely; BUS_ERR is tied to 0; no counter logic is built.

Test Plan:
- Read, 3 words, HOLD=0:
  - stimulus: RA0W DSO=0x0001000, DMAW DIR=0; bus returns 0xA,0xB,0xC with ACK after 3 clocks;
  - expect BUS_ADDR 0x0004000/0x0004004/0x0004008, DMA_DI 0xA/0xB/0xC on each DMA_ACK;
  - expect DMA_END pulse over 2 CE_F, then RA0=0x0001003.
- Write, ADD=011, HOLD=1:
  - stimulus: WA0=0x10, 2 words 0x11111111 and 0x22222222;
  - expect BUS_ADDR 0x40 then 0x50, BUS_WE=1, BUS_DO matching;
  - expect WA0 still 0x10 after DMA_END.
- Wrap: RA0=0x1FFFFFF, 2-word read → BUS_ADDR 0x7FFFFFC then 0x0000000.
- CE_R alignment: CE_R every 4th clock, BUS_ACK on a non-CE_R clock → DMA_ACK held until the next CE_R clock, then exactly one word consumed.
- Reset mid-BUSW with BUS_REQ=1 → next clock all outputs 0, state IDLE, no DMA_END edge.
- SCUDSP_DMA_TIMEOUT_EN, TIMEOUT_CYC=8, BUS_ACK withheld → after 8 clocks DMA_ACK with DMA_DI=0, BUS_ERR=1 and stays 1 after DMA_END.
